// File: rtl/pipeline_mem_stage.sv
// MEM stage: sized loads/stores over a split read/write bus, one instruction in flight.
// Optional macro MEM_ALIGN_CHECK_EN rejects illegal accesses with a mem_err pulse instead of forcing alignment.
module pipeline_mem_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   ex_res,
    input  logic [DATA_WIDTH-1:0]   r2_val,
    input  logic [4:0]              dst_reg,
    input  logic [1:0]              mem_op,
    input  logic [1:0]              mem_size,
    input  logic                    mem_unsigned,
    output logic                    wb_enable,
    output logic [4:0]              wb_dst_reg,
    output logic [DATA_WIDTH-1:0]   wb_dst_val,
    output logic                    mem_err,
    output logic [ADDR_WIDTH-1:0]   S_R_ADDR,
    output logic                    S_R_ADDR_VALID,
    input  logic                    S_R_ADDR_READY,
    input  logic [DATA_WIDTH-1:0]   S_R_DATA,
    input  logic                    S_R_DATA_VALID,
    output logic                    S_R_DATA_READY,
    output logic [ADDR_WIDTH-1:0]   S_W_ADDR,
    output logic [DATA_WIDTH-1:0]   S_W_DATA,
    output logic [DATA_WIDTH/8-1:0] S_W_STRB,
    output logic                    S_W_VALID,
    input  logic                    S_W_READY,
    input  logic                    S_W_DONE
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    localparam bit IS_32  = (DATA_WIDTH == 32);

    typedef enum logic [2:0] {IDLE, R_REQ, R_WAIT, W_REQ, W_WAIT} state_t;

    state_t r_state, w_state_next;

    function automatic logic [2:0] size_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    logic                  w_idle, w_accept, w_is_load, w_is_store, w_wide, w_illegal;
    logic [1:0]            w_eff_size;
    logic [2:0]            w_force_mask;
    logic [DATA_WIDTH-1:0] w_eff_addr, w_aligned;
    logic [LANE_W-1:0]     w_lane;
    logic [7:0]            w_bytes;

    assign w_idle     = (r_state == IDLE);
    assign w_accept   = in_valid && w_idle;
    assign w_is_load  = (mem_op == 2'd1);
    assign w_is_store = (mem_op == 2'd2);
    assign w_wide     = IS_32 && (mem_size == 2'd3);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_eff_size   = mem_size;
    assign w_force_mask = 3'b000;
    assign w_illegal    = w_wide || ((ex_res[2:0] & size_mask(mem_size)) != 3'b000);
`else
    // Oversized accesses on a 32-bit bus degrade to a word; low bits are forced to alignment.
    assign w_eff_size   = w_wide ? 2'd2 : mem_size;
    assign w_force_mask = size_mask(w_eff_size);
    assign w_illegal    = 1'b0;
`endif

    assign w_eff_addr = {ex_res[DATA_WIDTH-1:3], ex_res[2:0] & ~w_force_mask};
    assign w_lane     = w_eff_addr[LANE_W-1:0];
    assign w_aligned  = {w_eff_addr[DATA_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
    assign w_bytes    = byte_mask(w_eff_size);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        in_ready       = 1'b0;
        S_R_ADDR_VALID = 1'b0;
        S_R_DATA_READY = 1'b0;
        S_W_VALID      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !w_illegal) begin
                    if (w_is_load) begin
                        w_state_next = R_REQ;
                    end else if (w_is_store) begin
                        w_state_next = W_REQ;
                    end
                end
            end
            R_REQ: begin
                S_R_ADDR_VALID = 1'b1;
                if (S_R_ADDR_READY) begin
                    w_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                S_R_DATA_READY = 1'b1;
                if (S_R_DATA_VALID) begin
                    w_state_next = IDLE;
                end
            end
            W_REQ: begin
                S_W_VALID = 1'b1;
                if (S_W_READY) begin
                    w_state_next = S_W_DONE ? IDLE : W_WAIT;
                end
            end
            W_WAIT: begin
                if (S_W_DONE) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    logic [4:0]            r_dst;
    logic [1:0]            r_size;
    logic [LANE_W-1:0]     r_lane;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NB-1:0]         r_wr_strb;
    logic                  r_wb_en, r_mem_err;
    logic [4:0]            r_wb_dst;
    logic [DATA_WIDTH-1:0] r_wb_val;

    // Load extraction: shift the addressed lane down, then sign/zero fill above the access width.
    logic [DATA_WIDTH-1:0] w_shifted, w_load_val;
    logic [6:0]            w_nbits;
    logic                  w_sign;

    assign w_shifted = S_R_DATA >> {r_lane, 3'b000};
    assign w_nbits   = 7'd8 << r_size;

    always_comb begin
        w_sign = 1'b0;
        case (r_size)
            2'd0:    w_sign = w_shifted[7];
            2'd1:    w_sign = w_shifted[15];
            2'd2:    w_sign = w_shifted[31];
            default: w_sign = w_shifted[DATA_WIDTH-1];
        endcase
        if (r_unsigned) begin
            w_sign = 1'b0;
        end
    end

    genvar gi;
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
        assign w_load_val[gi] = (7'(gi) < w_nbits) ? w_shifted[gi] : w_sign;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dst      <= '0;
            r_size     <= '0;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
            r_wb_en    <= 1'b0;
            r_mem_err  <= 1'b0;
            r_wb_dst   <= '0;
            r_wb_val   <= '0;
        end else begin
            r_wb_en   <= 1'b0;
            r_mem_err <= 1'b0;
            if (w_accept) begin
                r_dst      <= dst_reg;
                r_size     <= w_eff_size;
                r_lane     <= w_lane;
                r_unsigned <= mem_unsigned;
                if ((w_is_load || w_is_store) && w_illegal) begin
                    r_mem_err <= 1'b1;
                end else if (w_is_load) begin
                    r_rd_addr <= ADDR_WIDTH'(w_aligned);
                end else if (w_is_store) begin
                    r_wr_addr <= ADDR_WIDTH'(w_aligned);
                    r_wr_data <= r2_val << {w_lane, 3'b000};
                    r_wr_strb <= w_bytes[NB-1:0] << w_lane;
                end else begin
                    r_wb_en  <= (dst_reg != 5'd0);
                    r_wb_dst <= dst_reg;
                    r_wb_val <= ex_res;
                end
            end
            if ((r_state == R_WAIT) && S_R_DATA_VALID) begin
                r_wb_en  <= (r_dst != 5'd0);
                r_wb_dst <= r_dst;
                r_wb_val <= w_load_val;
            end
        end
    end

    assign wb_enable  = r_wb_en;
    assign wb_dst_reg = r_wb_dst;
    assign wb_dst_val = r_wb_val;
    assign mem_err    = r_mem_err;
    assign S_R_ADDR   = r_rd_addr;
    assign S_W_ADDR   = r_wr_addr;
    assign S_W_DATA   = r_wr_data;
    assign S_W_STRB   = r_wr_strb;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Bench for pipeline_mem_stage: directed plan steps plus random ops against an arithmetic reference model.
module tb_pipeline_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] ex_res, r2_val;
    logic [4:0]  dst_reg;
    logic [1:0]  mem_op, mem_size;
    logic        mem_unsigned;
    logic        wb_enable;
    logic [4:0]  wb_dst_reg;
    logic [63:0] wb_dst_val;
    logic        mem_err;
    logic [63:0] S_R_ADDR;
    logic        S_R_ADDR_VALID, S_R_ADDR_READY;
    logic [63:0] S_R_DATA;
    logic        S_R_DATA_VALID, S_R_DATA_READY;
    logic [63:0] S_W_ADDR, S_W_DATA;
    logic [7:0]  S_W_STRB;
    logic        S_W_VALID, S_W_READY, S_W_DONE;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_res(ex_res), .r2_val(r2_val), .dst_reg(dst_reg),
        .mem_op(mem_op), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .wb_enable(wb_enable), .wb_dst_reg(wb_dst_reg), .wb_dst_val(wb_dst_val),
        .mem_err(mem_err),
        .S_R_ADDR(S_R_ADDR), .S_R_ADDR_VALID(S_R_ADDR_VALID), .S_R_ADDR_READY(S_R_ADDR_READY),
        .S_R_DATA(S_R_DATA), .S_R_DATA_VALID(S_R_DATA_VALID), .S_R_DATA_READY(S_R_DATA_READY),
        .S_W_ADDR(S_W_ADDR), .S_W_DATA(S_W_DATA), .S_W_STRB(S_W_STRB),
        .S_W_VALID(S_W_VALID), .S_W_READY(S_W_READY), .S_W_DONE(S_W_DONE)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("%s observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] eff_addr(input logic [63:0] a, input logic [1:0] s);
`ifdef MEM_ALIGN_CHECK_EN
        return a;
`else
        return a - (a % (64'd1 << s));
`endif
    endfunction

    function automatic bit illegal(input logic [63:0] a, input logic [1:0] s);
`ifdef MEM_ALIGN_CHECK_EN
        return (a % (64'd1 << s)) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] load_model(input logic [63:0] word, input int lane,
                                               input logic [1:0] s, input bit uns);
        int nbits = 8 << s;
        logic [63:0] v = word >> (8 * lane);
        logic [63:0] mask = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] r2,
                          input logic [1:0] size, input bit uns, input logic [4:0] dst,
                          input logic [63:0] rdata, input int a_dly, input int d_dly,
                          input bit same_done);
        logic [63:0] ea   = eff_addr(addr, size);
        int          lane = int'(ea % 64'd8);
        logic [63:0] base = ea - (ea % 64'd8);
        logic [63:0] exp_data = r2 << (8 * lane);
        logic [7:0]  exp_strb = 8'(((16'd1 << (1 << size)) - 16'd1) << lane);
        bit          is_mem = (op == 2'd1) || (op == 2'd2);

        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1; ex_res = addr; r2_val = r2; dst_reg = dst;
        mem_op = op; mem_size = size; mem_unsigned = uns;
        step();
        in_valid = 1'b0; mem_op = 2'd0; ex_res = {$urandom, $urandom};

        if (!is_mem) begin
            check("alu_wb_en", wb_enable, dst != 5'd0);
            if (dst != 5'd0) begin
                check("alu_wb_dst", wb_dst_reg, dst);
                check("alu_wb_val", wb_dst_val, addr);
            end
            check("alu_mem_err", mem_err, 0);
            step();
            check("alu_wb_pulse", wb_enable, 0);
        end else if (illegal(addr, size)) begin
            check("err_pulse", mem_err, 1);
            check("err_no_rvalid", S_R_ADDR_VALID, 0);
            check("err_no_wvalid", S_W_VALID, 0);
            check("err_no_wb", wb_enable, 0);
            check("err_in_ready", in_ready, 1);
            step();
            check("err_pulse_end", mem_err, 0);
        end else if (op == 2'd1) begin
            for (int i = 0; i <= a_dly; i++) begin
                check("rd_addr_valid", S_R_ADDR_VALID, 1);
                check("rd_addr", S_R_ADDR, base);
                check("rd_busy", in_ready, 0);
                S_R_ADDR_READY = (i == a_dly);
                step();
                S_R_ADDR_READY = 1'b0;
            end
            for (int i = 0; i <= d_dly; i++) begin
                check("rd_data_ready", S_R_DATA_READY, 1);
                check("rd_addr_dropped", S_R_ADDR_VALID, 0);
                S_R_DATA       = (i == d_dly) ? rdata : {$urandom, $urandom};
                S_R_DATA_VALID = (i == d_dly);
                step();
                S_R_DATA_VALID = 1'b0;
                S_R_DATA       = {$urandom, $urandom};
            end
            check("ld_wb_en", wb_enable, dst != 5'd0);
            if (dst != 5'd0) begin
                check("ld_wb_dst", wb_dst_reg, dst);
                check("ld_wb_val", wb_dst_val, load_model(rdata, lane, size, uns));
            end
            check("ld_done_ready", in_ready, 1);
            check("ld_mem_err", mem_err, 0);
            step();
            check("ld_wb_pulse", wb_enable, 0);
        end else begin
            for (int i = 0; i <= a_dly; i++) begin
                check("wr_valid", S_W_VALID, 1);
                check("wr_addr", S_W_ADDR, base);
                check("wr_data", S_W_DATA, exp_data);
                check("wr_strb", S_W_STRB, exp_strb);
                check("wr_busy", in_ready, 0);
                S_W_READY = (i == a_dly);
                S_W_DONE  = (i == a_dly) && same_done;
                step();
                S_W_READY = 1'b0;
                S_W_DONE  = 1'b0;
            end
            if (!same_done) begin
                for (int i = 0; i <= d_dly; i++) begin
                    check("wr_wait_valid", S_W_VALID, 0);
                    check("wr_wait_busy", in_ready, 0);
                    S_W_DONE = (i == d_dly);
                    step();
                    S_W_DONE = 1'b0;
                end
            end
            check("st_done_ready", in_ready, 1);
            check("st_no_wb", wb_enable, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; ex_res = '0; r2_val = '0; dst_reg = '0;
        mem_op = '0; mem_size = '0; mem_unsigned = 1'b0;
        S_R_ADDR_READY = 1'b0; S_R_DATA = '0; S_R_DATA_VALID = 1'b0;
        S_W_READY = 1'b0; S_W_DONE = 1'b0;
        step();
        step();

        check("rst_in_ready", in_ready, 1);
        check("rst_rvalid", S_R_ADDR_VALID, 0);
        check("rst_rready", S_R_DATA_READY, 0);
        check("rst_wvalid", S_W_VALID, 0);
        check("rst_wb_en", wb_enable, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_raddr", S_R_ADDR, 0);
        check("rst_waddr", S_W_ADDR, 0);
        check("rst_wdata", S_W_DATA, 0);
        check("rst_wstrb", S_W_STRB, 0);
        reset = 1'b0;
        step();

        // ALU passthrough, with and without a destination
        run_op(2'd0, 64'h1234, 64'h0, 2'd0, 1'b0, 5'd5, 64'h0, 0, 0, 1'b0);
        run_op(2'd0, 64'h1234, 64'h0, 2'd0, 1'b0, 5'd0, 64'h0, 0, 0, 1'b0);
        // Signed byte load with a 3-cycle address stall
        run_op(2'd1, 64'h1003, 64'h0, 2'd0, 1'b0, 5'd3, 64'h0000_0000_8000_0000, 3, 0, 1'b0);
        // Unsigned half load from the top lane
        run_op(2'd1, 64'h2006, 64'h0, 2'd1, 1'b1, 5'd4, 64'hBEEF_0000_0000_0000, 0, 1, 1'b0);
        // Word store acknowledged and completed in one cycle
        run_op(2'd2, 64'h3004, 64'hDEAD_BEEF, 2'd2, 1'b0, 5'd9, 64'h0, 0, 0, 1'b1);
        // Misaligned word load
        run_op(2'd1, 64'h4002, 64'h0, 2'd2, 1'b0, 5'd6, 64'h1122_3344_8899_AABB, 0, 0, 1'b0);
        // Store with a separate completion phase
        run_op(2'd2, 64'h5002, 64'hCAFE, 2'd1, 1'b0, 5'd1, 64'h0, 2, 2, 1'b0);

        // Reset while waiting on read data; a late response must be ignored
        check("rst_mid_ready", in_ready, 1);
        in_valid = 1'b1; mem_op = 2'd1; ex_res = 64'h6000; mem_size = 2'd3; dst_reg = 5'd7;
        step();
        in_valid = 1'b0; mem_op = 2'd0;
        S_R_ADDR_READY = 1'b1;
        step();
        S_R_ADDR_READY = 1'b0;
        check("rst_mid_in_rwait", S_R_DATA_READY, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_idle", in_ready, 1);
        check("rst_mid_rready", S_R_DATA_READY, 0);
        check("rst_mid_rvalid", S_R_ADDR_VALID, 0);
        S_R_DATA = 64'h0123_4567_89AB_CDEF; S_R_DATA_VALID = 1'b1;
        step();
        S_R_DATA_VALID = 1'b0;
        check("rst_late_no_wb", wb_enable, 0);
        check("rst_late_idle", in_ready, 1);
        step();
        check("rst_late_no_wb2", wb_enable, 0);

        // Random mix of ops, sizes, lanes and bus delays
        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_mem_stage.md
# pipeline_mem_stage

Memory (MEM) stage of the in-order pipeline, sitting between execute and writeback. It accepts one instruction at a time and runs sized loads and stores over the split read/write memory bus. Loads are sign- or zero-extended; stores drive byte strobes. The stage stalls the pipeline through `in_ready` until each bus transaction completes, then issues a single registered writeback.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: bus and effective-address width.
- `DATA_WIDTH`, 64: bus data width; legal values are 32 and 64. `NB = DATA_WIDTH/8`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1 / `in_ready` out 1: instruction handshake from execute.
- `ex_res` in `DATA_WIDTH`: ALU result; this is the effective address for loads and stores.
- `r2_val` in `DATA_WIDTH`: store data.
- `dst_reg` in 5: destination register.
- `mem_op` in 2: 0 = none, 1 = load, 2 = store, 3 = treated as none.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `mem_unsigned` in 1: zero-extend loads when set.
- `wb_enable` out 1, `wb_dst_reg` out 5, `wb_dst_val` out `DATA_WIDTH`: writeback.
- `mem_err` out 1: one-cycle pulse on an illegal access.
- `S_R_ADDR` out `ADDR_WIDTH`, `S_R_ADDR_VALID` out 1, `S_R_ADDR_READY` in 1: read address channel.
- `S_R_DATA` in `DATA_WIDTH`, `S_R_DATA_VALID` in 1, `S_R_DATA_READY` out 1: read data channel.
- `S_W_ADDR` out `ADDR_WIDTH`, `S_W_DATA` out `DATA_WIDTH`, `S_W_STRB` out `NB`, `S_W_VALID` out 1, `S_W_READY` in 1, `S_W_DONE` in 1: write channel.

## Operation
- States: IDLE, R_REQ, R_WAIT, W_REQ, W_WAIT. `in_ready = (state == IDLE)`.
- Accept happens when `in_valid && in_ready`. On accept the stage latches `ex_res`, `r2_val`, `dst_reg`, `mem_size` and `mem_unsigned`.
- Non-memory op: no state change. Next cycle `wb_enable=1`, `wb_dst_val=ex_res`.
- `wb_enable` is never asserted when `dst_reg == 0`; this applies to every op.
- Load, IDLE to R_REQ:
  - In R_REQ: `S_R_ADDR_VALID=1`, `S_R_ADDR = addr` with the low `log2(NB)` bits cleared. Move to R_WAIT on `S_R_ADDR_READY`.
  - In R_WAIT: `S_R_DATA_READY=1`. On `S_R_DATA_VALID`, select lane `addr[log2(NB)-1:0]` of width `8<<mem_size` and extend it (sign unless `mem_unsigned`).
  - Writeback pulse comes the next cycle; the state returns to IDLE on the same edge as the data capture.
- Store, IDLE to W_REQ:
  - In W_REQ: `S_W_VALID=1`. `S_W_ADDR` is the aligned address.
  - `S_W_DATA` is `r2_val` shifted left by `8*lane`.
  - `S_W_STRB` is `((1<<(1<<mem_size))-1) << lane`.
  - On `S_W_READY`, go to W_WAIT. If `S_W_DONE` is also high in that cycle, go directly to IDLE.
  - In W_WAIT, return to IDLE on `S_W_DONE`. Stores never assert `wb_enable`.
- An illegal access is either misaligned (`addr mod (1<<mem_size) != 0`) or `mem_size=3` with `DATA_WIDTH=32`. Handling depends on `MEM_ALIGN_CHECK_EN` (see Configuration).
- Bus address and data outputs hold their values while the corresponding valid is high and unacknowledged.

## Timing
- Reset values: state IDLE; `in_ready=1`; all valids, `S_R_DATA_READY`, `wb_enable` and `mem_err` are 0; data, address and strobe outputs are 0.
- All outputs are registered or decoded from state. There is no combinational path from bus inputs to bus outputs.
- Non-memory latency: accept at cycle N gives `wb_enable` at N+1.
- Load with a zero-wait bus: accept at N; `S_R_ADDR_VALID` at N+1; `S_R_DATA_READY` at N+2; data valid at N+2; `wb_enable` at N+3.
- `S_R_DATA_VALID` is ignored outside R_WAIT. `S_W_DONE` is ignored outside W_REQ and W_WAIT.
- `wb_enable` and `mem_err` are single-cycle pulses.
- Reset mid-transaction returns to IDLE on the next edge and drops all valids and readies. Late bus responses after reset are ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An illegal access produces no bus transaction and no writeback.
  - `mem_err=1` the cycle after accept; the state stays IDLE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - The low address bits below the access size are forced to 0 and the access proceeds.
  - A `mem_size=3` access on 32-bit builds is performed as a word.
  - `mem_err` is tied to 0.

## Test plan
- ALU passthrough: `mem_op=0`, `ex_res=0x1234`, `dst_reg=5` -> cycle after accept `wb_enable=1`, `wb_dst_reg=5`, `wb_dst_val=0x1234`. Repeat with `dst_reg=0` -> `wb_enable` stays 0.
- Signed byte load: addr `0x1003`, size 0, signed. Bus returns `0x00000000_80000000` with `S_R_ADDR_READY` delayed 3 cycles -> `S_R_ADDR=0x1000` held 4 cycles; `wb_dst_val=0xFFFFFFFF_FFFFFF80`; `in_ready=0` throughout.
- Unsigned half load: addr `0x2006`, data `0xBEEF_0000_0000_0000` -> `wb_dst_val=0xBEEF`.
- Word store: addr `0x3004`, `r2_val=0xDEADBEEF`, `S_W_READY` and `S_W_DONE` in the same cycle -> `S_W_STRB=0xF0`, `S_W_DATA=0xDEADBEEF_00000000`, back to IDLE on the next edge, no writeback.
- Misaligned word load at `0x4002`:
  - With `MEM_ALIGN_CHECK_EN`: `mem_err` pulses, no `S_R_ADDR_VALID`.
  - Without it: read at `0x4000`, `mem_err=0`.
- Reset asserted while in R_WAIT, then `S_R_DATA_VALID` pulses -> state IDLE, no `wb_enable`, `in_ready=1`.
